// File: rtl/dict_compare_stage.sv
// Byte-wise compare of each accepted word against a FIFO-replacement dictionary,
// producing one registered 4-bit match vector per entry for the word_decoder bank.
module dict_compare_stage #(
   parameter  int unsigned DICT_DEPTH = 16,
   localparam int unsigned PTR_W      = $clog2(DICT_DEPTH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_clear,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [31:0]             i_word,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [31:0]             o_word,
   output logic                    o_zero,
   output logic [4*DICT_DEPTH-1:0] o_compare_vec,
   output logic [DICT_DEPTH-1:0]   o_entry_valid
);

   logic [31:0]             dict [DICT_DEPTH];
   logic [DICT_DEPTH-1:0]   entry_valid;
   logic [DICT_DEPTH-1:0]   cmp_valid;
   logic [DICT_DEPTH-1:0]   next_valid;
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        base_ptr;
   logic [4*DICT_DEPTH-1:0] cmp_vec;
   logic                    full_hit;
   logic                    accept;
   logic                    push;

   assign o_ready = ~o_valid | i_ready;
   assign accept  = i_valid & o_ready;

   // A clear in the same cycle makes the compare and the push see an empty dictionary.
   assign cmp_valid = i_clear ? '0 : entry_valid;
   assign base_ptr  = i_clear ? '0 : wr_ptr;

   always_comb begin
      cmp_vec  = '0;
      full_hit = 1'b0;
      for (int unsigned k = 0; k < DICT_DEPTH; k++) begin
         for (int unsigned b = 0; b < 4; b++) begin
            cmp_vec[4*k+b] = cmp_valid[k] & (dict[k][8*b +: 8] == i_word[8*b +: 8]);
         end
         if (cmp_vec[4*k +: 4] == 4'hF) begin
            full_hit = 1'b1;
         end
      end
   end

   assign push = accept & ~full_hit & (i_word != '0);

   always_comb begin
      next_valid = cmp_valid;
      if (push) begin
         next_valid[base_ptr] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid       <= 1'b0;
         o_word        <= '0;
         o_zero        <= 1'b0;
         o_compare_vec <= '0;
         o_entry_valid <= '0;
         entry_valid   <= '0;
         wr_ptr        <= '0;
      end else begin
         if (accept) begin
            o_valid       <= 1'b1;
            o_word        <= i_word;
            o_zero        <= (i_word == '0);
            o_compare_vec <= cmp_vec;
            o_entry_valid <= cmp_valid;
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end
         entry_valid <= next_valid;
         wr_ptr      <= push ? base_ptr + PTR_W'(1) : base_ptr;
      end
   end

   // Entry data needs no reset: it is never observed while its valid bit is low.
   always_ff @(posedge i_clk) begin
      if (push) begin
         dict[base_ptr] <= i_word;
      end
   end

endmodule

// File: tb/tb_dict_compare_stage.sv
// Directed bench for dict_compare_stage: scoreboard of expected outputs plus
// constant checks on the observed vectors at the interesting points.
module tb_dict_compare_stage;

   localparam int unsigned DEPTH = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                clear;
   logic                valid;
   logic                ready_out;
   logic [31:0]         word;
   logic                ovalid;
   logic                ready_in;
   logic [31:0]         oword;
   logic                ozero;
   logic [4*DEPTH-1:0]  vec;
   logic [DEPTH-1:0]    ev;

   always #5 clk = ~clk;

   dict_compare_stage #(.DICT_DEPTH(DEPTH)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_clear       (clear),
      .i_valid       (valid),
      .o_ready       (ready_out),
      .i_word        (word),
      .o_valid       (ovalid),
      .i_ready       (ready_in),
      .o_word        (oword),
      .o_zero        (ozero),
      .o_compare_vec (vec),
      .o_entry_valid (ev)
   );

   typedef struct packed {
      logic [31:0]        w;
      logic               z;
      logic [4*DEPTH-1:0] v;
      logic [DEPTH-1:0]   e;
   } exp_t;

   exp_t        sb[$];
   exp_t        obs_last;
   logic [31:0] m_dict [DEPTH];
   logic [DEPTH-1:0] m_valid;
   int unsigned m_ptr;
   int          errors = 0;
   int          checks = 0;
   int          n_push = 0;
   int          n_pop  = 0;
   logic [31:0] wk;
   logic [31:0] w_first;
   logic [31:0] w_last;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model_eval(input logic [31:0] w, input logic clr);
      exp_t r;
      r.w = w;
      r.z = (w == 32'h0);
      r.e = clr ? '0 : m_valid;
      r.v = '0;
      for (int k = 0; k < DEPTH; k++)
         for (int b = 0; b < 4; b++)
            r.v[4*k+b] = r.e[k] && (m_dict[k][8*b +: 8] == w[8*b +: 8]);
      return r;
   endfunction

   task automatic model_update(input logic [31:0] w, input logic clr, input exp_t r);
      logic hit;
      hit = 1'b0;
      if (clr) begin
         m_valid = '0;
         m_ptr   = 0;
      end
      for (int k = 0; k < DEPTH; k++)
         if (r.v[4*k +: 4] == 4'hF) hit = 1'b1;
      if (!hit && w != 32'h0) begin
         m_dict[m_ptr]  = w;
         m_valid[m_ptr] = 1'b1;
         m_ptr          = (m_ptr + 1) % DEPTH;
      end
   endtask

   // One clock: check outputs against the scoreboard head, then account for acceptance.
   task automatic step();
      logic  had_out;
      logic  acc;
      exp_t  r;
      @(negedge clk);
      had_out = (sb.size() != 0);
      check("o_valid", ovalid, had_out);
      check("o_ready", ready_out, !had_out || ready_in);
      if (had_out) begin
         check("o_word", oword, sb[0].w);
         check("o_zero", ozero, sb[0].z);
         check("o_compare_vec", vec, sb[0].v);
         check("o_entry_valid", ev, sb[0].e);
         if (ready_in) begin
            obs_last.w = oword;
            obs_last.z = ozero;
            obs_last.v = vec;
            obs_last.e = ev;
            void'(sb.pop_front());
            n_pop++;
         end
      end
      acc = valid && (!had_out || ready_in);
      if (acc) begin
         r = model_eval(word, clear);
         sb.push_back(r);
         n_push++;
         model_update(word, clear, r);
      end else if (clear) begin
         m_valid = '0;
         m_ptr   = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      valid    = 1'b1;
      word     = w;
      ready_in = 1'b1;
      step();
      valid    = 1'b0;
   endtask

   task automatic drain();
      valid    = 1'b0;
      ready_in = 1'b1;
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("rst o_valid", ovalid, 1'b0);
      check("rst o_word", oword, 32'h0);
      check("rst o_zero", ozero, 1'b0);
      check("rst o_compare_vec", vec, '0);
      check("rst o_entry_valid", ev, '0);
      valid    = 1'b0;
      clear    = 1'b0;
      ready_in = 1'b1;
      word     = 32'h0;
      sb.delete();
      n_push  = 0;
      n_pop   = 0;
      m_valid = '0;
      m_ptr   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; valid = 1'b0; ready_in = 1'b1; word = 32'h0;
      do_reset();

      // First word sees an empty dictionary
      send(32'hAABBCCDD);
      drain();
      check("t1 vec", obs_last.v, '0);
      check("t1 ev", obs_last.e, '0);

      // Back-to-back partial match, then proof of the push into entry1
      do_reset();
      send(32'hAABBCCDD);
      send(32'hAABB1234);
      drain();
      check("t2 vec0", obs_last.v[3:0], 4'b1100);
      check("t2 ev", obs_last.e, 16'h0001);
      send(32'hAABB1234);
      drain();
      check("t2 vec1", obs_last.v[7:4], 4'b1111);
      check("t2 ev2", obs_last.e, 16'h0003);

      // Full hit and zero word do not push
      do_reset();
      send(32'hAABBCCDD);
      send(32'hAABBCCDD);
      drain();
      check("t3 full", obs_last.v[3:0], 4'b1111);
      check("t3 ev", obs_last.e, 16'h0001);
      send(32'h0);
      drain();
      check("t3 zero", obs_last.z, 1'b1);
      check("t3 ev0", obs_last.e, 16'h0001);
      send(32'h01020304);
      send(32'h01020304);
      drain();
      check("t3 ptr1", obs_last.v[7:4], 4'b1111);

      // Wrap-around after DEPTH+1 distinct pushes
      do_reset();
      for (int k = 0; k <= DEPTH; k++) begin
         wk = 32'h01020304 * (k + 1);
         send(wk);
      end
      w_first = 32'h01020304;
      w_last  = 32'h01020304 * (DEPTH + 1);
      send(w_last);
      drain();
      check("t4 entry0", obs_last.v[3:0], 4'b1111);
      check("t4 ev", obs_last.e, 16'hFFFF);
      send(32'hDEADBEEF);
      send(32'hDEADBEEF);
      drain();
      check("t4 ptr1", obs_last.v[7:4], 4'b1111);
      send(w_first);
      drain();
      for (int k = 0; k < DEPTH; k++)
         check("t4 no old", (obs_last.v[4*k +: 4] == 4'hF), 1'b0);

      // Backpressure: stall three cycles, then stream
      do_reset();
      valid = 1'b1; ready_in = 1'b1; word = 32'h10203040;
      step();
      ready_in = 1'b0; word = 32'h10203041;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5 stall ready", ready_out, 1'b0);
      end
      ready_in = 1'b1;
      step();
      word = 32'h10203042;
      step();
      word = 32'h10203040;
      step();
      valid = 1'b0;
      drain();
      check("t5 resend vec0", obs_last.v[3:0], 4'b1111);
      check("t5 count", n_pop, 4);
      check("t5 no dup", n_push, n_pop);

      // Clear coincident with an accepted word
      do_reset();
      send(32'h11223344);
      send(32'h55667788);
      send(32'h99AABBCC);
      clear = 1'b1;
      send(32'h11223344);
      clear = 1'b0;
      drain();
      check("t6 vec", obs_last.v, '0);
      check("t6 ev", obs_last.e, '0);
      send(32'h11223344);
      drain();
      check("t6 entry0", obs_last.v[3:0], 4'b1111);
      check("t6 ev1", obs_last.e, 16'h0001);
      send(32'h55667788);
      drain();
      check("t6 gone", obs_last.v[3:0], 4'b0000);

      // Asynchronous reset in the middle of a burst
      valid = 1'b1; ready_in = 1'b1; word = 32'h0BADF00D;
      step();
      word = 32'h0BADF00E;
      step();
      #1;
      rst_n = 1'b0;
      #1;
      check("t6 rst o_valid", ovalid, 1'b0);
      check("t6 rst vec", vec, '0);
      do_reset();
      send(32'h0BADF00D);
      drain();
      check("t6 post rst ev", obs_last.e, '0);
      check("t6 post rst vec", obs_last.v, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
